// File: rtl/lsram_arb_pkg.sv
// Shared encodings for the LSRAM port arbiter: FSM states, owner identifiers
// and the AHB HSIZE values used on the command ports.
`timescale 1ns/1ps
package lsram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_U = 2'd1,
        GNT_S = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_U = 1'b0,
        OWN_S = 1'b1
    } owner_t;

    localparam logic [2:0] SZ_BYTE = 3'b000;
    localparam logic [2:0] SZ_HALF = 3'b001;
    localparam logic [2:0] SZ_WORD = 3'b010;

endpackage

// File: rtl/lsram_arb_pick.sv
// Owner selection for the LSRAM arbiter: fixed SII priority with a starvation
// guard, or round-robin, plus the history registers both policies need.
`timescale 1ns/1ps
module lsram_arb_pick
    import lsram_arb_pkg::*;
#(
    parameter int RR_EN        = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic   HCLK,
    input  logic   aresetn,
    input  logic   pend_u,
    input  logic   pend_s,
    input  logic   grant,
    output owner_t pick
);

    logic [3:0] starve_cnt;
    owner_t     last_owner;

    always_comb begin
        pick = OWN_U;
        if (pend_s && !pend_u) begin
            pick = OWN_S;
        end else if (pend_s && pend_u) begin
            if (RR_EN != 0) begin
                pick = (last_owner == OWN_U) ? OWN_S : OWN_U;
            end else begin
                pick = (starve_cnt == 4'(STARVE_LIMIT)) ? OWN_U : OWN_S;
            end
        end
    end

    // starve_cnt only counts SII wins that actually kept a waiting UII out
    always_ff @(posedge HCLK or negedge aresetn) begin
        if (!aresetn) begin
            starve_cnt <= '0;
            last_owner <= OWN_U;
        end else if (grant) begin
            last_owner <= pick;
            if (pick == OWN_U) begin
                starve_cnt <= '0;
            end else if (pend_u && starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/lsram_port_arbiter.sv
// Shares one LSRAM command port between the AHB slave interface (UII) and a
// secondary initiator (SII); one owner at a time, ack/rdata routed to the owner.
`timescale 1ns/1ps
module lsram_port_arbiter
    import lsram_arb_pkg::*;
#(
    parameter int MEM_AWIDTH   = 19,
    parameter int DWIDTH       = 32,
    parameter int RR_EN        = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  HCLK,
    input  logic                  aresetn,
    input  logic                  uii_req,
    input  logic                  uii_write,
    input  logic [2:0]            uii_size,
    input  logic [MEM_AWIDTH-1:0] uii_addr,
    input  logic [DWIDTH-1:0]     uii_wdata,
    output logic                  uii_ack,
    output logic [DWIDTH-1:0]     uii_rdata,
    input  logic                  sii_req,
    input  logic                  sii_write,
    input  logic [2:0]            sii_size,
    input  logic [MEM_AWIDTH-1:0] sii_addr,
    input  logic [DWIDTH-1:0]     sii_wdata,
    output logic                  sii_ack,
    output logic [DWIDTH-1:0]     sii_rdata,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic [2:0]            mem_size,
    output logic [MEM_AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DWIDTH-1:0]     mem_rdata,
    output logic                  busy,
    output logic                  proto_err
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       pend_u;
    logic       pend_s;
    logic       grant;
    owner_t     pick;

    assign grant     = (state == IDLE) && (pend_u || pend_s);
    assign uii_ack   = (state == GNT_U) && mem_ack;
    assign sii_ack   = (state == GNT_S) && mem_ack;
    assign uii_rdata = uii_ack ? mem_rdata : '0;
    assign sii_rdata = sii_ack ? mem_rdata : '0;
    assign busy      = pend_s || (state == GNT_S);

    lsram_arb_pick #(
        .RR_EN        (RR_EN),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .HCLK    (HCLK),
        .aresetn (aresetn),
        .pend_u  (pend_u),
        .pend_s  (pend_s),
        .grant   (grant),
        .pick    (pick)
    );

    // A new request in the ack cycle re-arms the port, so set wins over clear
    always_ff @(posedge HCLK or negedge aresetn) begin
        if (!aresetn) begin
            pend_u    <= 1'b0;
            pend_s    <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            pend_u <= uii_req || (pend_u && !uii_ack);
            pend_s <= sii_req || (pend_s && !sii_ack);
            if ((uii_req && pend_u && !uii_ack) || (sii_req && pend_s && !sii_ack)) begin
                proto_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:         if (grant) state_nxt = (pick == OWN_S) ? GNT_S : GNT_U;
            GNT_U, GNT_S: if (mem_ack) state_nxt = IDLE;
            default:      state_nxt = IDLE;
        endcase
    end

    // Command is captured at grant so the SRAM side keeps it through IDLE
    always_ff @(posedge HCLK or negedge aresetn) begin
        if (!aresetn) begin
            mem_req   <= 1'b0;
            mem_write <= 1'b0;
            mem_size  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_req <= grant;
            if (grant) begin
                if (pick == OWN_S) begin
                    mem_write <= sii_write;
                    mem_size  <= sii_size;
                    mem_addr  <= sii_addr;
                    mem_wdata <= sii_wdata;
                end else begin
                    mem_write <= uii_write;
                    mem_size  <= uii_size;
                    mem_addr  <= uii_addr;
                    mem_wdata <= uii_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsram_port_arbiter.sv
// Randomized and directed bench for lsram_port_arbiter: two instances (fixed
// priority and round-robin) checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_lsram_port_arbiter;
    import lsram_arb_pkg::*;

    localparam int AW    = 19;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic HCLK;
    logic aresetn;

    logic          uii_req   [2];
    logic          uii_write [2];
    logic [2:0]    uii_size  [2];
    logic [AW-1:0] uii_addr  [2];
    logic [DW-1:0] uii_wdata [2];
    logic          sii_req   [2];
    logic          sii_write [2];
    logic [2:0]    sii_size  [2];
    logic [AW-1:0] sii_addr  [2];
    logic [DW-1:0] sii_wdata [2];
    logic          mem_ack   [2];
    logic [DW-1:0] mem_rdata [2];

    wire           uii_ack   [2];
    wire  [DW-1:0] uii_rdata [2];
    wire           sii_ack   [2];
    wire  [DW-1:0] sii_rdata [2];
    wire           mem_req   [2];
    wire           mem_write [2];
    wire  [2:0]    mem_size  [2];
    wire  [AW-1:0] mem_addr  [2];
    wire  [DW-1:0] mem_wdata [2];
    wire           busy      [2];
    wire           proto_err [2];

    lsram_port_arbiter #(.MEM_AWIDTH(AW), .DWIDTH(DW), .RR_EN(0), .STARVE_LIMIT(LIMIT)) dut0 (
        .HCLK(HCLK), .aresetn(aresetn),
        .uii_req(uii_req[0]), .uii_write(uii_write[0]), .uii_size(uii_size[0]),
        .uii_addr(uii_addr[0]), .uii_wdata(uii_wdata[0]), .uii_ack(uii_ack[0]), .uii_rdata(uii_rdata[0]),
        .sii_req(sii_req[0]), .sii_write(sii_write[0]), .sii_size(sii_size[0]),
        .sii_addr(sii_addr[0]), .sii_wdata(sii_wdata[0]), .sii_ack(sii_ack[0]), .sii_rdata(sii_rdata[0]),
        .mem_req(mem_req[0]), .mem_write(mem_write[0]), .mem_size(mem_size[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_ack(mem_ack[0]), .mem_rdata(mem_rdata[0]),
        .busy(busy[0]), .proto_err(proto_err[0])
    );

    lsram_port_arbiter #(.MEM_AWIDTH(AW), .DWIDTH(DW), .RR_EN(1), .STARVE_LIMIT(LIMIT)) dut1 (
        .HCLK(HCLK), .aresetn(aresetn),
        .uii_req(uii_req[1]), .uii_write(uii_write[1]), .uii_size(uii_size[1]),
        .uii_addr(uii_addr[1]), .uii_wdata(uii_wdata[1]), .uii_ack(uii_ack[1]), .uii_rdata(uii_rdata[1]),
        .sii_req(sii_req[1]), .sii_write(sii_write[1]), .sii_size(sii_size[1]),
        .sii_addr(sii_addr[1]), .sii_wdata(sii_wdata[1]), .sii_ack(sii_ack[1]), .sii_rdata(sii_rdata[1]),
        .mem_req(mem_req[1]), .mem_write(mem_write[1]), .mem_size(mem_size[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_ack(mem_ack[1]), .mem_rdata(mem_rdata[1]),
        .busy(busy[1]), .proto_err(proto_err[1])
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state per instance; port 0 = UII, port 1 = SII, owner 0 = none
    int            m_owner [2];
    bit            m_pend  [2][2];
    bit            m_first [2];
    int            m_age   [2];
    int            m_starve[2];
    int            m_last  [2];
    bit            m_perr  [2];
    bit            c_write [2];
    logic [2:0]    c_size  [2];
    logic [AW-1:0] c_addr  [2];
    logic [DW-1:0] c_wdata [2];

    // Stimulus knobs and the command each port currently presents
    int            rate     [2][2];
    int            rereq    [2][2];
    int            quota    [2][2];
    bit            issue    [2][2];
    bit            dup      [2][2];
    int            ack_pct  [2];
    int            ack_delay[2];
    bit            use_fix  [2];
    logic [DW-1:0] rd_fix   [2];
    bit            f_write  [2][2];
    logic [2:0]    f_size   [2][2];
    logic [AW-1:0] f_addr   [2][2];
    logic [DW-1:0] f_wdata  [2][2];

    // What the DUTs were seen doing; grant owner is recovered from the address top bit
    bit            glog     [2][64];
    int            gcnt     [2];
    int            uack_cnt [2];
    int            sack_cnt [2];
    bit            busy_seen[2];
    logic [DW-1:0] s_rd_last[2];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        m_owner[k] = 0; m_first[k] = 0; m_age[k] = 0; m_starve[k] = 0; m_last[k] = 0; m_perr[k] = 0;
        m_pend[k][0] = 0; m_pend[k][1] = 0;
        c_write[k] = 0; c_size[k] = '0; c_addr[k] = '0; c_wdata[k] = '0;
    endtask

    function automatic int choose(input int k);
        if (!m_pend[k][1]) return 0;
        if (!m_pend[k][0]) return 1;
        if (k == 1) return 1 - m_last[k];
        return (m_starve[k] == LIMIT) ? 0 : 1;
    endfunction

    task automatic model_step(input int k);
        bit ack [2];
        bit req [2];
        int p;
        ack[0] = mem_ack[k] && m_owner[k] == 1;
        ack[1] = mem_ack[k] && m_owner[k] == 2;
        req[0] = uii_req[k];
        req[1] = sii_req[k];
        for (int q = 0; q < 2; q++)
            if (req[q] && m_pend[k][q] && !ack[q]) m_perr[k] = 1;
        m_first[k] = 0;
        if (m_owner[k] == 0) begin
            if (m_pend[k][0] || m_pend[k][1]) begin
                p = choose(k);
                m_owner[k] = p + 1;
                m_first[k] = 1;
                m_age[k]   = 0;
                c_write[k] = (p == 0) ? uii_write[k] : sii_write[k];
                c_size[k]  = (p == 0) ? uii_size[k]  : sii_size[k];
                c_addr[k]  = (p == 0) ? uii_addr[k]  : sii_addr[k];
                c_wdata[k] = (p == 0) ? uii_wdata[k] : sii_wdata[k];
                if (p == 0) m_starve[k] = 0;
                else if (m_pend[k][0] && m_starve[k] < 15) m_starve[k]++;
                m_last[k] = p;
            end
        end else if (ack[m_owner[k] - 1]) begin
            m_owner[k] = 0;
        end else begin
            m_age[k]++;
        end
        for (int q = 0; q < 2; q++) m_pend[k][q] = req[q] || (m_pend[k][q] && !ack[q]);
    endtask

    task automatic check_dut(input int k);
        bit ua, sa;
        ua = mem_ack[k] && m_owner[k] == 1;
        sa = mem_ack[k] && m_owner[k] == 2;
        checkOutput($sformatf("d%0d.mem_req", k),   mem_req[k],   m_first[k]);
        checkOutput($sformatf("d%0d.mem_write", k), mem_write[k], c_write[k]);
        checkOutput($sformatf("d%0d.mem_size", k),  mem_size[k],  c_size[k]);
        checkOutput($sformatf("d%0d.mem_addr", k),  mem_addr[k],  c_addr[k]);
        checkOutput($sformatf("d%0d.mem_wdata", k), mem_wdata[k], c_wdata[k]);
        checkOutput($sformatf("d%0d.uii_ack", k),   uii_ack[k],   ua);
        checkOutput($sformatf("d%0d.uii_rdata", k), uii_rdata[k], ua ? mem_rdata[k] : '0);
        checkOutput($sformatf("d%0d.sii_ack", k),   sii_ack[k],   sa);
        checkOutput($sformatf("d%0d.sii_rdata", k), sii_rdata[k], sa ? mem_rdata[k] : '0);
        checkOutput($sformatf("d%0d.busy", k),      busy[k],      m_pend[k][1] || m_owner[k] == 2);
        checkOutput($sformatf("d%0d.proto_err", k), proto_err[k], m_perr[k]);
    endtask

    task automatic observe(input int k);
        if (mem_req[k] === 1'b1 && gcnt[k] < 64) begin
            glog[k][gcnt[k]] = mem_addr[k][AW-1];
            gcnt[k]++;
        end
        if (uii_ack[k] === 1'b1) uack_cnt[k]++;
        if (sii_ack[k] === 1'b1) begin
            sack_cnt[k]++;
            s_rd_last[k] = sii_rdata[k];
        end
        if (busy[k] === 1'b1) busy_seen[k] = 1;
    endtask

    // Compare mid-cycle, then advance the model with the inputs held for the next edge
    always @(negedge HCLK) begin
        for (int k = 0; k < 2; k++) begin
            if (!aresetn) model_reset(k);
            check_dut(k);
            observe(k);
            if (aresetn) model_step(k);
        end
    end

    task automatic clear_obs();
        for (int k = 0; k < 2; k++) begin
            gcnt[k] = 0; uack_cnt[k] = 0; sack_cnt[k] = 0; busy_seen[k] = 0; s_rd_last[k] = '0;
        end
    endtask

    task automatic set_fields(input int k, input int p, input bit w, input logic [2:0] sz,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        f_write[k][p] = w; f_size[k][p] = sz; f_addr[k][p] = a; f_wdata[k][p] = d;
    endtask

    // SII addresses live in the upper half so grants can be told apart on mem_addr
    task automatic rand_fields(input int k, input int p);
        logic [2:0] sz;
        logic [AW-2:0] low;
        case ($urandom_range(2))
            0:       sz = SZ_BYTE;
            1:       sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        low = (AW-1)'($urandom);
        set_fields(k, p, 1'($urandom_range(1)), sz, {p[0], low}, $urandom);
    endtask

    task automatic applyStimulus();
        for (int k = 0; k < 2; k++) begin
            bit ack;
            if (ack_delay[k] > 0) ack = (m_owner[k] != 0) && (m_age[k] == ack_delay[k]);
            else                  ack = ($urandom_range(99) < ack_pct[k]);
            mem_ack[k]   = ack;
            mem_rdata[k] = use_fix[k] ? rd_fix[k] : $urandom;
            for (int p = 0; p < 2; p++) begin
                bit acking, req;
                acking = ack && (m_owner[k] == p + 1);
                req = 0;
                if (issue[k][p]) begin
                    req = 1;
                    issue[k][p] = 0;
                end else if (quota[k][p] > 0 &&
                             ((!m_pend[k][p] && $urandom_range(99) < rate[k][p]) ||
                              (acking && $urandom_range(99) < rereq[k][p]))) begin
                    req = 1;
                    quota[k][p]--;
                    rand_fields(k, p);
                end else if (dup[k][p] && m_pend[k][p] && !acking) begin
                    req = 1;
                    dup[k][p] = 0;
                end
                if (p == 0) begin
                    uii_req[k] = req; uii_write[k] = f_write[k][0]; uii_size[k] = f_size[k][0];
                    uii_addr[k] = f_addr[k][0]; uii_wdata[k] = f_wdata[k][0];
                end else begin
                    sii_req[k] = req; sii_write[k] = f_write[k][1]; sii_size[k] = f_size[k][1];
                    sii_addr[k] = f_addr[k][1]; sii_wdata[k] = f_wdata[k][1];
                end
            end
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge HCLK);
            #1;
            applyStimulus();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_pend[0][0] || m_pend[0][1] || m_pend[1][0] || m_pend[1][1] ||
                m_owner[0] != 0 || m_owner[1] != 0) && n < 300) begin
            run_cycles(1);
            n++;
        end
        if (n >= 300) checkOutput("drain_timeout", 1, 0);
    endtask

    task automatic set_knobs(input int r, input int rr, input int qt, input int ap, input int ad);
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                rate[k][p] = r; rereq[k][p] = rr; quota[k][p] = qt; issue[k][p] = 0; dup[k][p] = 0;
            end
            ack_pct[k] = ap; ack_delay[k] = ad; use_fix[k] = 0; rd_fix[k] = '0;
        end
    endtask

    initial begin
        int n;
        aresetn = 1'b0;
        set_knobs(0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) set_fields(k, p, 0, SZ_BYTE, '0, '0);
            model_reset(k);
        end
        clear_obs();
        applyStimulus();
        run_cycles(3);
        aresetn = 1'b1;

        // Lone UII write, SRAM answers two cycles after mem_req
        clear_obs();
        set_knobs(0, 0, 0, 0, 2);
        for (int k = 0; k < 2; k++) begin
            set_fields(k, 0, 1, SZ_WORD, 19'h00100, 32'hA5A5_A5A5);
            issue[k][0] = 1;
        end
        run_cycles(10);
        checkOutput("t1_grants", gcnt[0], 1);
        checkOutput("t1_uack", uack_cnt[0], 1);
        checkOutput("t1_busy", busy_seen[0], 0);

        // Simultaneous requests: SII read wins under fixed priority
        clear_obs();
        set_knobs(0, 0, 0, 0, 2);
        for (int k = 0; k < 2; k++) begin
            use_fix[k] = 1; rd_fix[k] = 32'h1234_5678;
            set_fields(k, 0, 1, SZ_WORD, 19'h00200, 32'hCAFE_0001);
            set_fields(k, 1, 0, SZ_WORD, 19'h40010, 32'h0);
            issue[k][0] = 1; issue[k][1] = 1;
        end
        run_cycles(16);
        checkOutput("t2_grants", gcnt[0], 2);
        checkOutput("t2_first_s", glog[0][0], 1);
        checkOutput("t2_then_u", glog[0][1], 0);
        checkOutput("t2_srdata", s_rd_last[0], 32'h1234_5678);
        checkOutput("t2_uack", uack_cnt[0], 1);

        // SII re-requests on every ack while UII waits
        clear_obs();
        set_knobs(0, 0, 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            rereq[k][1] = 100; quota[k][1] = 20;
            rand_fields(k, 0); rand_fields(k, 1);
            issue[k][0] = 1; issue[k][1] = 1;
        end
        run_cycles(60);
        for (int k = 0; k < 2; k++) rereq[k][1] = 0;
        drain();
        checkOutput("t3_len", gcnt[0] >= 5, 1);
        for (int i = 0; i < 5; i++)
            if (i < gcnt[0]) checkOutput($sformatf("t3_grant%0d", i), glog[0][i], (i < 4) ? 1 : 0);

        // Round-robin with both ports back-to-back, six requests each
        clear_obs();
        set_knobs(0, 100, 5, 0, 1);
        for (int k = 0; k < 2; k++) begin
            rand_fields(k, 0); rand_fields(k, 1);
            issue[k][0] = 1; issue[k][1] = 1;
        end
        run_cycles(60);
        drain();
        checkOutput("t4_len", gcnt[1], 12);
        n = 0;
        for (int i = 0; i < gcnt[1] && i < 12; i++) begin
            if (glog[1][i]) n++;
            if (i > 0) checkOutput($sformatf("t4_alt%0d", i), glog[1][i] ^ glog[1][i-1], 1);
        end
        checkOutput("t4_scount", n, 6);

        // Random traffic on both instances
        clear_obs();
        set_knobs(30, 30, 100000, 35, 0);
        run_cycles(1500);
        set_knobs(0, 0, 0, 35, 0);
        drain();

        // Duplicate UII request while the first is still pending
        clear_obs();
        set_knobs(0, 0, 0, 0, 3);
        for (int k = 0; k < 2; k++) begin
            rand_fields(k, 0);
            issue[k][0] = 1; dup[k][0] = 1;
        end
        run_cycles(12);
        checkOutput("t5_grants", gcnt[0], 1);
        checkOutput("t5_uack", uack_cnt[0], 1);
        checkOutput("t5_perr", proto_err[0], 1);
        run_cycles(3);
        checkOutput("t5_perr_sticky", proto_err[0], 1);

        // Reset while SII owns the memory; a late ack must not reach SII
        clear_obs();
        set_knobs(0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            set_fields(k, 1, 0, SZ_WORD, 19'h40040, 32'h0);
            issue[k][1] = 1;
        end
        n = 0;
        while (m_owner[0] != 2 && n < 20) begin
            run_cycles(1);
            n++;
        end
        checkOutput("t6_owner_s", m_owner[0] == 2, 1);
        aresetn = 1'b0;
        run_cycles(2);
        aresetn = 1'b1;
        mem_ack[0] = 1'b1;
        mem_ack[1] = 1'b1;
        run_cycles(2);
        for (int k = 0; k < 2; k++) begin
            ack_delay[k] = 2;
            set_fields(k, 0, 1, SZ_HALF, 19'h00300, 32'h0000_BEEF);
            issue[k][0] = 1;
        end
        run_cycles(12);
        checkOutput("t6_no_sack", sack_cnt[0], 0);
        checkOutput("t6_uack", uack_cnt[0], 1);
        checkOutput("t6_no_sack_rr", sack_cnt[1], 0);
        checkOutput("t6_uack_rr", uack_cnt[1], 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
